domain_transfer_mc: RTL and testbench

Parametrised successor to the Montgomery domain converter. It converts NUM_CH residues per transaction into or out of the Montgomery domain by k iterations of modular doubling (x·2^k mod p) or modular halving (x·2^-k mod p). The shift count k is selectable at runtime. Transactions use a valid/ready handshake on both sides. It sits between the host interface and the ECC point-arithmetic core, and is reused for curve constants and point coordinates.

---
 rtl/ecc_pkg.sv | 17 +
 rtl/mod_step.sv | 25 ++
 rtl/domain_transfer_mc.sv | 121 ++++++++++++
 tb/tb_domain_transfer_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC domain-conversion blocks.
package ecc_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NUM_CH = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic int clamp_k(input int amt, input int width);
      return (amt > width) ? width : amt;
   endfunction

endpackage

// File: rtl/mod_step.sv
// One modular doubling (dir=1) or halving (dir=0) step on a residue x < p, p odd.
module mod_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] p,
   input  logic             dir,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH:0] dbl;

   assign dbl = {x, 1'b0};

   always_comb begin
      y = '0;
      if (dir) begin
         y = (dbl >= {1'b0, p}) ? (dbl[WIDTH-1:0] - p) : dbl[WIDTH-1:0];
      end else begin
         // (x+p)/2 for odd x and odd p, rearranged so the carry never leaves WIDTH bits
         y = (x >> 1) + (x[0] ? ((p >> 1) + WIDTH'(1)) : '0);
      end
   end

endmodule

// File: rtl/domain_transfer_mc.sv
// Converts NUM_CH residues into (x*2^k mod p) or out of (x*2^-k mod p) the Montgomery domain.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   RUN   | one doubling/halving step per cycle on all channels
//   OUT   | result presented, held until out_ready
module domain_transfer_mc
   import ecc_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = $clog2(WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    to_mont,
   input  logic [CNT_W-1:0]        shift_amt,
   input  logic [WIDTH-1:0]        prime,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic                    err,
   output logic                    busy
);

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        k_reg;
   logic [CNT_W-1:0]        k_in;
   logic                    dir;
   logic [WIDTH-1:0]        p_reg;
   logic [NUM_CH*WIDTH-1:0] ch;
   logic [NUM_CH*WIDTH-1:0] ch_red;
   logic [NUM_CH*WIDTH-1:0] ch_nxt;
   logic                    prime_bad;

   assign k_in      = CNT_W'(clamp_k(int'(shift_amt), WIDTH));
   assign prime_bad = !prime[0] || (prime < WIDTH'(3));

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] x_in;
      assign x_in = in_data[gi*WIDTH +: WIDTH];
      // inputs arrive below 2p, so one conditional subtract fully reduces them
      assign ch_red[gi*WIDTH +: WIDTH] = (x_in >= prime) ? (x_in - prime) : x_in;

      mod_step #(.WIDTH(WIDTH)) u_step (
         .x   (ch[gi*WIDTH +: WIDTH]),
         .p   (p_reg),
         .dir (dir),
         .y   (ch_nxt[gi*WIDTH +: WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         k_reg     <= '0;
         dir       <= 1'b0;
         p_reg     <= '0;
         ch        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  p_reg    <= prime;
                  dir      <= to_mont;
                  k_reg    <= k_in;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (prime_bad) begin
                     ch        <= '0;
                     out_data  <= '0;
                     err       <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else if (k_in == '0) begin
                     ch        <= ch_red;
                     out_data  <= ch_red;
                     err       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     ch    <= ch_red;
                     err   <= 1'b0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               ch  <= ch_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == k_reg - CNT_W'(1)) begin
                  out_data  <= ch_nxt;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_domain_transfer_mc.sv
// Scoreboard bench for domain_transfer_mc: directed requests, monitor checks results and latency.
module tb_domain_transfer_mc;

   localparam int W  = 32;
   localparam int N  = 3;
   localparam int CW = $clog2(W + 1);

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           in_valid = 1'b0;
   logic           to_mont = 1'b0;
   logic           out_ready = 1'b1;
   logic [CW-1:0]  shift_amt = '0;
   logic [W-1:0]   prime = '0;
   logic [N*W-1:0] in_data = '0;
   logic           in_ready;
   logic           out_valid;
   logic           err;
   logic           busy;
   logic [N*W-1:0] out_data;

   domain_transfer_mc #(.WIDTH(W), .NUM_CH(N), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .to_mont   (to_mont),
      .shift_amt (shift_amt),
      .prime     (prime),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*W-1:0] data;
      logic           e;
      int             lat;
      int             acc;
      string          name;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   presenting = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      return {c, b, a};
   endfunction

   // monitor: pops expectations when a result appears, checks it is held while stalled
   initial begin
      exp_t cur;
      forever begin
         @(negedge clk);
         if (!out_valid) begin
            presenting = 1'b0;
         end else begin
            if (!presenting) begin
               presenting = 1'b1;
               if (sbq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got %h want no output", out_data);
                  cur.data = out_data;
                  cur.e    = err;
                  cur.name = "unexpected";
               end else begin
                  cur = sbq.pop_front();
                  chk({cur.name, "_data"}, out_data, cur.data);
                  chk({cur.name, "_err"}, err, cur.e);
                  chk({cur.name, "_lat"}, cyc - cur.acc + 1, cur.lat);
               end
            end else begin
               chk({cur.name, "_hold_data"}, out_data, cur.data);
               chk({cur.name, "_hold_err"}, err, cur.e);
            end
            chk({cur.name, "_out_in_ready"}, in_ready, 1'b0);
            chk({cur.name, "_out_busy"}, busy, 1'b1);
            if (out_ready) presenting = 1'b0;
         end
      end
   end

   task automatic send(input logic [W-1:0] p, input logic tm, input logic [CW-1:0] k,
                       input logic [W-1:0] x0, input logic [W-1:0] x1, input logic [W-1:0] x2,
                       input bit expect_out, input logic [N*W-1:0] exp_d, input logic exp_e,
                       input int exp_lat, input string name, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      prime     = p;
      to_mont   = tm;
      shift_amt = k;
      in_data   = {x2, x1, x0};
      in_valid  = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL %s_accept: got no in_ready want accept within 200 cycles", name);
         in_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (expect_out) sbq.push_back('{exp_d, exp_e, exp_lat, acc, name});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0 within 200 cycles", sbq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int hs;
      int n;

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_out_data", out_data, '0);
      @(negedge clk) reset = 1'b1;

      send(13, 1, 32, 1, 15, 0, 1, pk(9, 5, 0), 0, 33, "t1_mont", acc);
      drain();
      send(13, 0, 32, 9, 5, 0, 1, pk(1, 2, 0), 0, 33, "t2_back", acc);
      drain();
      send(13, 0, 1, 1, 0, 0, 1, pk(7, 0, 0), 0, 2, "t2_half1", acc);
      drain();
      send(32'hFFFF_FFFB, 1, 1, 32'hFFFF_FFFA, 0, 0, 1, pk(32'hFFFF_FFF9, 0, 0), 0, 2,
           "t3_dbl_carry", acc);
      drain();
      send(32'hFFFF_FFFB, 0, 1, 32'hFFFF_FFF9, 0, 0, 1, pk(32'hFFFF_FFFA, 0, 0), 0, 2,
           "t3_half_carry", acc);
      drain();
      send(7, 0, 5, 3, 6, 13, 1, pk(6, 5, 5), 0, 6, "t_p7_half5", acc);
      drain();
      send(12, 1, 5, 1, 2, 3, 1, pk(0, 0, 0), 1, 1, "t4_even_p", acc);
      drain();
      send(1, 1, 5, 1, 0, 0, 1, pk(0, 0, 0), 1, 1, "t4_p1", acc);
      drain();
      send(13, 1, 0, 20, 0, 0, 1, pk(7, 0, 0), 0, 1, "t4_k0", acc);
      drain();
      send(13, 1, 63, 1, 15, 0, 1, pk(9, 5, 0), 0, 33, "t4_clamp", acc);
      drain();

      // backpressure: stall the result, then queue the next request behind the handshake
      out_ready = 1'b0;
      send(13, 1, 1, 3, 7, 12, 1, pk(6, 1, 11), 0, 2, "t5_bp", acc);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      hs = cyc + 1;
      send(13, 0, 2, 1, 2, 4, 1, pk(10, 7, 1), 0, 3, "t5_next", acc);
      chk("t5_bubble_accept_cycle", acc, hs + 1);
      chk("t5_after_hs_data", out_data, pk(6, 1, 11));
      chk("t5_after_hs_valid", out_valid, 1'b0);
      drain();

      // abort a long conversion with reset when the counter reaches 10
      send(13, 1, 32, 5, 5, 5, 0, '0, 0, 0, "t6_abort", acc);
      repeat (10) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_rst_in_ready", in_ready, 1'b1);
      chk("t6_rst_out_valid", out_valid, 1'b0);
      chk("t6_rst_out_data", out_data, '0);
      chk("t6_rst_busy", busy, 1'b0);
      @(negedge clk) reset = 1'b1;
      send(11, 1, 3, 1, 2, 0, 1, pk(8, 5, 0), 0, 4, "t6_after", acc);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
